// File: rtl/ks_pkg.sv
// ks_pkg: shared helpers for the pipelined Kogge-Stone adder.
//   - ks_levels / ks_stages : prefix depth and pipeline stage count
//   - gp_t                  : (generate, propagate) pair handled by prefix cells
//   - gray_cell / black_cell: the two Kogge-Stone prefix operators
package ks_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Number of prefix levels for a WIDTH-bit adder.
    function automatic int ks_levels(input int width);
        return $clog2(width);
    endfunction

    // Register stages = ceil(levels / pipe_every); the last one is the output register.
    function automatic int ks_stages(input int width, input int pipe_every);
        return (ks_levels(width) + pipe_every - 1) / pipe_every;
    endfunction

    // Gray cell: group already reaches the carry-in, so only G is needed.
    function automatic logic gray_cell(input logic g_hi, input logic p_hi, input logic g_lo);
        return g_hi | (p_hi & g_lo);
    endfunction

    // Black cell: full (G, P) combine.
    function automatic gp_t black_cell(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/ks_pipe_slice.sv
// ks_pipe_slice: one valid/ready register slice with a DATA_W-bit payload.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   upstream handshake (in_ready is combinational from out_ready)
//   in_data               payload from upstream
//   out_valid / out_ready downstream handshake
//   out_data              registered payload, held while stalled
module ks_pipe_slice #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    // Slice may load when empty or when its current item leaves this cycle.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // NOTE: sequential state uses non-blocking assignments so every slice samples
    // its neighbour's pre-edge value, giving a true shift rather than a ripple.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            // NOTE: the payload is reset too, because the output slice must present
            // zero results after reset, not whatever was in flight.
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/kogge_stone_pipe.sv
// kogge_stone_pipe: pipelined WIDTH-bit Kogge-Stone adder/subtractor.
//   {cout, sum} = a + (b ^ {WIDTH{sub}}) + cin ; ovf = signed overflow.
// A register slice follows every PIPE_EVERY prefix levels and the sum stage,
// giving a latency of ceil(log2(WIDTH)/PIPE_EVERY) cycles at 1 op/cycle.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    operand handshake
//   a, b, cin, sub         operands, carry-in (not-borrow when sub=1), subtract select
//   out_valid / out_ready  result handshake
//   sum, cout, ovf         result, carry-out of MSB, signed overflow
//   zero, neg              result flags, only when KS_FLAGS_EN is defined
// Build option: define KS_FLAGS_EN to add the zero/neg flag outputs.
module kogge_stone_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int PIPE_EVERY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef KS_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg
`endif
);

    localparam int LEVELS = ks_levels(WIDTH);
    localparam int STAGES = ks_stages(WIDTH, PIPE_EVERY);

    // Prefix state between stages. Index j of gp/gg is bit position j-1, so
    // gg[0] is the carry-in acting as g[-1] (with p[-1]=0). After all levels
    // gg[j] = G[j-1:-1], the carry into bit j.
    typedef struct packed {
        logic [WIDTH-1:0] p;      // bitwise propagate a ^ b_eff, kept for the sum
        logic [WIDTH-1:0] gp;     // group propagate
        logic [WIDTH-1:0] gg;     // group generate, cin folded into gg[0]
        logic             a_msb;
        logic             b_msb;  // MSB of b_eff
    } ks_state_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
`ifdef KS_FLAGS_EN
        logic             zero;
        logic             neg;
`endif
    } ks_result_t;

    function automatic ks_state_t pre_process(input logic [WIDTH-1:0] op_a,
                                              input logic [WIDTH-1:0] op_b,
                                              input logic op_cin, input logic op_sub);
        ks_state_t        st;
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH-1:0] p;
        b_eff    = op_b ^ {WIDTH{op_sub}};
        p        = op_a ^ b_eff;
        st.p     = p;
        st.gp    = {p[WIDTH-2:0], 1'b0};
        st.gg    = {op_a[WIDTH-2:0] & b_eff[WIDTH-2:0], op_cin};
        st.a_msb = op_a[WIDTH-1];
        st.b_msb = b_eff[WIDTH-1];
        return st;
    endfunction

    // Prefix level k: combine with distance 2^(k-1). Positions whose new span
    // reaches the carry-in (j < 2^k) use gray cells, the rest black cells.
    function automatic ks_state_t ks_level(input ks_state_t st, input int k);
        ks_state_t r;
        gp_t       c;
        int        d;
        r = st;
        d = 1 << (k - 1);
        for (int j = 0; j < WIDTH; j++) begin
            if (j >= 2 * d) begin
                c       = black_cell(gp_t'({st.gg[j], st.gp[j]}), gp_t'({st.gg[j-d], st.gp[j-d]}));
                r.gg[j] = c.g;
                r.gp[j] = c.p;
            end else if (j >= d) begin
                r.gg[j] = gray_cell(st.gg[j], st.gp[j], st.gg[j-d]);
                r.gp[j] = 1'b0;   // span includes p[-1]=0
            end
        end
        return r;
    endfunction

    function automatic ks_result_t ks_sum(input ks_state_t st);
        ks_result_t res;
        res.sum  = st.p ^ st.gg;
        res.cout = gray_cell(st.a_msb & st.b_msb, st.p[WIDTH-1], st.gg[WIDTH-1]);
        res.ovf  = (st.a_msb == st.b_msb) && (res.sum[WIDTH-1] != st.a_msb);
`ifdef KS_FLAGS_EN
        res.zero = (res.sum == '0);
        res.neg  = res.sum[WIDTH-1];
`endif
        return res;
    endfunction

    ks_state_t         seg_in [STAGES];
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_ready;
    ks_result_t        res_q;

    assign seg_in[0] = pre_process(a, b, cin, sub);
    assign in_ready  = stage_ready[0];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int FIRST = s * PIPE_EVERY + 1;
        localparam int LAST  = ((s + 1) * PIPE_EVERY < LEVELS) ? (s + 1) * PIPE_EVERY : LEVELS;

        ks_state_t seg_out;
        logic      up_valid;
        logic      down_ready;

        // NOTE: seg_out is assigned before any read or conditional update, so
        // every path writes it and no latch is inferred.
        always_comb begin
            seg_out = seg_in[s];
            for (int k = FIRST; k <= LAST; k++) begin
                seg_out = ks_level(seg_out, k);
            end
        end

        if (s == 0) begin : g_up_in
            assign up_valid = in_valid;
        end else begin : g_up_stage
            assign up_valid = stage_valid[s-1];
        end

        if (s < STAGES - 1) begin : g_mid
            assign down_ready = stage_ready[s+1];
            ks_pipe_slice #(.DATA_W($bits(ks_state_t))) u_slice (
                .clk      (clk),
                .rst      (rst),
                .in_valid (up_valid),
                .in_ready (stage_ready[s]),
                .in_data  (seg_out),
                .out_valid(stage_valid[s]),
                .out_ready(down_ready),
                .out_data (seg_in[s+1])
            );
        end else begin : g_out
            ks_result_t res_d;
            assign down_ready = out_ready;
            assign res_d      = ks_sum(seg_out);
            ks_pipe_slice #(.DATA_W($bits(ks_result_t))) u_slice (
                .clk      (clk),
                .rst      (rst),
                .in_valid (up_valid),
                .in_ready (stage_ready[s]),
                .in_data  (res_d),
                .out_valid(stage_valid[s]),
                .out_ready(down_ready),
                .out_data (res_q)
            );
        end
    end

    assign out_valid = stage_valid[STAGES-1];
    assign sum       = res_q.sum;
    assign cout      = res_q.cout;
    assign ovf       = res_q.ovf;
`ifdef KS_FLAGS_EN
    assign zero      = res_q.zero;
    assign neg       = res_q.neg;
`endif

endmodule
